// File: rtl/atomrvcore_wb_unit.sv
// Write-back unit: merges ALU results (through a one-entry skid) with in-order load
// responses onto the single register-file write port and tracks outstanding loads.
module atomrvcore_wb_unit #(
  parameter int unsigned DATAWIDTH        = 32,
  parameter int unsigned REGISTERS        = 32,
  parameter int unsigned REG_ADRESS_WIDTH = 5,
  parameter int unsigned LQ_DEPTH         = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        alu_valid_i,
  output logic                        alu_ready_o,
  input  logic [REG_ADRESS_WIDTH-1:0] alu_rd_i,
  input  logic [DATAWIDTH-1:0]        alu_data_i,
  input  logic                        ld_issue_valid_i,
  output logic                        ld_issue_ready_o,
  input  logic [REG_ADRESS_WIDTH-1:0] ld_rd_i,
  input  logic [2:0]                  ld_funct3_i,
  input  logic [1:0]                  ld_off_i,
  input  logic                        mem_rvalid_i,
  input  logic [DATAWIDTH-1:0]        mem_rdata_i,
  output logic                        rwr_en_o,
  output logic [REG_ADRESS_WIDTH-1:0] rd_o,
  output logic [DATAWIDTH-1:0]        wr_data_o,
  output logic [REGISTERS-1:0]        pend_mask_o,
  output logic                        err_o
);

  localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [REG_ADRESS_WIDTH-1:0] lq_rd_q  [LQ_DEPTH];
  logic [2:0]                  lq_f3_q  [LQ_DEPTH];
  logic [1:0]                  lq_off_q [LQ_DEPTH];
  logic [PTR_W-1:0]            wptr_q, rptr_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic                        skid_v_q, skid_v_d;
  logic [REG_ADRESS_WIDTH-1:0] skid_rd_q, skid_rd_d;
  logic [DATAWIDTH-1:0]        skid_data_q, skid_data_d;

  logic                        rwr_en_q;
  logic [REG_ADRESS_WIDTH-1:0] rd_q;
  logic [DATAWIDTH-1:0]        wr_data_q;
  logic                        err_q;

  logic                        full, empty, push, pop, alu_fire;
  logic [REG_ADRESS_WIDTH-1:0] pop_rd;
  logic [2:0]                  pop_f3;
  logic [1:0]                  pop_off;
  logic [DATAWIDTH-1:0]        shifted, ld_data;
  logic                        sel_v;
  logic [REG_ADRESS_WIDTH-1:0] sel_rd;
  logic [DATAWIDTH-1:0]        sel_data;
  logic [REGISTERS-1:0]        pend_mask_c;
  logic [PTR_W-1:0]            idx;

  assign full             = (cnt_q == CNT_W'(LQ_DEPTH));
  assign empty            = (cnt_q == '0);
  assign push             = ld_issue_valid_i & ~full;
  assign pop              = mem_rvalid_i & ~empty;
  assign alu_fire         = alu_valid_i & ~skid_v_q;
  assign ld_issue_ready_o = ~full;
  assign alu_ready_o      = ~skid_v_q;

  // Extract and extend the load result from the head entry
  always_comb begin
    pop_rd  = lq_rd_q[rptr_q];
    pop_f3  = lq_f3_q[rptr_q];
    pop_off = lq_off_q[rptr_q];
    shifted = mem_rdata_i >> {pop_off, 3'b000};
    case (pop_f3)
      3'b000:  ld_data = {{(DATAWIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{(DATAWIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {{(DATAWIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  ld_data = {{(DATAWIDTH-16){1'b0}}, shifted[15:0]};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Write-port arbitration: load response, then skid, then fresh ALU result
  always_comb begin
    sel_v       = 1'b0;
    sel_rd      = alu_rd_i;
    sel_data    = alu_data_i;
    skid_v_d    = skid_v_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    if (pop) begin
      sel_v    = 1'b1;
      sel_rd   = pop_rd;
      sel_data = ld_data;
      if (alu_fire) begin
        skid_v_d    = 1'b1;
        skid_rd_d   = alu_rd_i;
        skid_data_d = alu_data_i;
      end
    end else if (skid_v_q) begin
      sel_v    = 1'b1;
      sel_rd   = skid_rd_q;
      sel_data = skid_data_q;
      skid_v_d = 1'b0;
    end else if (alu_fire) begin
      sel_v = 1'b1;
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pending mask covers only live entries, walking from the read pointer
  always_comb begin
    pend_mask_c = '0;
    idx         = '0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      idx = rptr_q + PTR_W'(i);
      if ((CNT_W'(i) < cnt_q) && (lq_rd_q[idx] != '0)) pend_mask_c[lq_rd_q[idx]] = 1'b1;
    end
  end

  assign pend_mask_o = pend_mask_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
        lq_rd_q[i]  <= '0;
        lq_f3_q[i]  <= '0;
        lq_off_q[i] <= '0;
      end
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      skid_v_q    <= 1'b0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
      rwr_en_q    <= 1'b0;
      rd_q        <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) begin
        lq_rd_q[wptr_q]  <= ld_rd_i;
        lq_f3_q[wptr_q]  <= ld_funct3_i;
        lq_off_q[wptr_q] <= ld_off_i;
        wptr_q           <= wptr_q + PTR_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      cnt_q       <= cnt_d;
      skid_v_q    <= skid_v_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      rwr_en_q    <= sel_v & (sel_rd != '0);
      if (sel_v && (sel_rd != '0)) begin
        rd_q      <= sel_rd;
        wr_data_q <= sel_data;
      end
      err_q <= err_q | (mem_rvalid_i & empty);
    end
  end

  assign rwr_en_o  = rwr_en_q;
  assign rd_o      = rd_q;
  assign wr_data_o = wr_data_q;
  assign err_o     = err_q;

endmodule
